huffman_multi_detect: RTL and testbench

- N-entry configurable Huffman code table with a registered lookup port.
- Each entry holds a code, its length and a data symbol. A lookup receives a C_W-bit MSB-aligned bit window and returns the symbol and length of the matching code.
- Sits between the bit-window aligner and the symbol output stage of the Huffman decoder path.
- Generalises the single-entry detector: table depth, variable code length, priority resolution, per-entry clear, valid/ready flow control.

---
 rtl/huffman_pkg.sv | 24 ++
 rtl/huffman_entry_cmp.sv | 71 +++++++
 rtl/huffman_multi_detect.sv | 116 +++++++++++
 tb/tb_huffman_multi_detect.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared types and constants for the multi-entry Huffman code detector.
//   len_width() : width of a code-length field able to hold 0..c_w
//   entry_t     : one table entry {code, len, sym, vld} at default widths
//   MISS_LEN    : match_len reported when no entry matches
package huffman_pkg;

    function automatic int len_width(input int c_w);
        return $clog2(c_w + 1);
    endfunction

    localparam int DEF_D_W = 4;
    localparam int DEF_C_W = 8;
    localparam int DEF_L_W = len_width(DEF_C_W);

    typedef struct packed {
        logic [DEF_C_W-1:0] code;
        logic [DEF_L_W-1:0] len;
        logic [DEF_D_W-1:0] sym;
        logic               vld;
    } entry_t;

    localparam int MISS_LEN = 0;

endpackage

// File: rtl/huffman_entry_cmp.sv
// One Huffman table entry: storage, valid flag and masked prefix compare.
// Ports:
//   clk, rst       clock / async active-low reset (clears valid flag only)
//   clr            clear the valid flag at the edge
//   wr             write code/len/sym and set valid at the edge
//   code_in, len_in, sym_in   entry contents to write
//   window         MSB-aligned lookup window
//   hit            entry is valid, has a legal length and its prefix matches
//   sym_out, len_out          stored symbol and length
module huffman_entry_cmp
    import huffman_pkg::*;
#(
    parameter int D_W = 4,
    parameter int C_W = 8,
    parameter int L_W = len_width(C_W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           wr,
    input  logic [C_W-1:0] code_in,
    input  logic [L_W-1:0] len_in,
    input  logic [D_W-1:0] sym_in,
    input  logic [C_W-1:0] window,
    output logic           hit,
    output logic [D_W-1:0] sym_out,
    output logic [L_W-1:0] len_out
);

    logic [C_W-1:0] code_q;
    logic [L_W-1:0] len_q;
    logic [D_W-1:0] sym_q;
    logic           vld_q;
    logic [C_W-1:0] mask;
    logic           len_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= 1'b0;
        end else if (clr) begin
            vld_q <= 1'b0;
        end else if (wr) begin
            vld_q <= 1'b1;
        end
    end

    // Contents are deliberately not reset; the valid flag gates them.
    always_ff @(posedge clk) begin
        if (wr) begin
            code_q <= code_in;
            len_q  <= len_in;
            sym_q  <= sym_in;
        end
    end

    // Mask covers the top len_q bits of the window.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < C_W; i++) begin
            if (i < 32'(len_q)) begin
                mask[C_W-1-i] = 1'b1;
            end
        end
    end

    assign len_ok  = (len_q != '0) && (len_q <= L_W'(C_W));
    assign hit     = vld_q && len_ok && (((window ^ code_q) & mask) == '0);
    assign sym_out = sym_q;
    assign len_out = len_q;

endmodule

// File: rtl/huffman_multi_detect.sv
// N-entry configurable Huffman code table with a registered lookup port.
// Ports:
//   clk, rst        clock / async active-low reset
//   new_conf        clear all entry valid flags (wins over en_conf)
//   en_conf, idx_conf, d_conf, h_conf, l_conf   write one entry
//   in_valid/in_ready      lookup request handshake, d2check is the window
//   out_valid/out_ready    result handshake
//   code_matched, data_decoded, match_len, match_idx   registered result
module huffman_multi_detect
    import huffman_pkg::*;
#(
    parameter  int D_W   = 4,
    parameter  int C_W   = 8,
    parameter  int N_ENT = 16,
    localparam int L_W   = len_width(C_W),
    localparam int I_W   = $clog2(N_ENT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           new_conf,
    input  logic           en_conf,
    input  logic [I_W-1:0] idx_conf,
    input  logic [D_W-1:0] d_conf,
    input  logic [C_W-1:0] h_conf,
    input  logic [L_W-1:0] l_conf,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [C_W-1:0] d2check,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           code_matched,
    output logic [D_W-1:0] data_decoded,
    output logic [L_W-1:0] match_len,
    output logic [I_W-1:0] match_idx
);

    logic [N_ENT-1:0] wr_sel;
    logic [N_ENT-1:0] hits;
    logic [D_W-1:0]   syms [N_ENT];
    logic [L_W-1:0]   lens [N_ENT];

    logic             any_hit;
    logic [I_W-1:0]   win_idx;
    logic [D_W-1:0]   win_sym;
    logic [L_W-1:0]   win_len;
    logic             accept;

    always_comb begin
        wr_sel = '0;
        if (en_conf && !new_conf) begin
            for (int unsigned i = 0; i < N_ENT; i++) begin
                if (idx_conf == I_W'(i)) begin
                    wr_sel[i] = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_ENT; g++) begin : g_ent
        huffman_entry_cmp #(
            .D_W(D_W),
            .C_W(C_W),
            .L_W(L_W)
        ) u_ent (
            .clk     (clk),
            .rst     (rst),
            .clr     (new_conf),
            .wr      (wr_sel[g]),
            .code_in (h_conf),
            .len_in  (l_conf),
            .sym_in  (d_conf),
            .window  (d2check),
            .hit     (hits[g]),
            .sym_out (syms[g]),
            .len_out (lens[g])
        );
    end

    // Lowest index wins; miss leaves all result fields at zero.
    always_comb begin
        any_hit = 1'b0;
        win_idx = '0;
        win_sym = '0;
        win_len = L_W'(MISS_LEN);
        for (int unsigned i = 0; i < N_ENT; i++) begin
            if (hits[i] && !any_hit) begin
                any_hit = 1'b1;
                win_idx = I_W'(i);
                win_sym = syms[i];
                win_len = lens[i];
            end
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            code_matched <= 1'b0;
            data_decoded <= '0;
            match_len    <= '0;
            match_idx    <= '0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            code_matched <= any_hit;
            data_decoded <= win_sym;
            match_len    <= win_len;
            match_idx    <= win_idx;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_huffman_multi_detect.sv
// Self-checking bench for huffman_multi_detect (default parameters).
module tb_huffman_multi_detect;
    import huffman_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       new_conf, en_conf;
    logic [3:0] idx_conf, d_conf, l_conf;
    logic [7:0] h_conf;
    logic       in_valid, in_ready;
    logic [7:0] d2check;
    logic       out_valid, out_ready, code_matched;
    logic [3:0] data_decoded, match_len, match_idx;

    logic [13:0] res;
    assign res = {out_valid, code_matched, data_decoded, match_len, match_idx};

    int errors = 0;
    int checks = 0;

    entry_t model [16];

    huffman_multi_detect #(.D_W(4), .C_W(8), .N_ENT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .new_conf     (new_conf),
        .en_conf      (en_conf),
        .idx_conf     (idx_conf),
        .d_conf       (d_conf),
        .h_conf       (h_conf),
        .l_conf       (l_conf),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .d2check      (d2check),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .code_matched (code_matched),
        .data_decoded (data_decoded),
        .match_len    (match_len),
        .match_idx    (match_idx)
    );

    always #5 clk = ~clk;

    // Reference: first valid entry whose top len bits equal the window's.
    function automatic logic [13:0] expect_lookup(input logic [7:0] win);
        for (int i = 0; i < 16; i++) begin
            int l;
            l = int'(model[i].len);
            if (model[i].vld && l >= 1 && l <= 8 &&
                ((win >> (8 - l)) == (model[i].code >> (8 - l)))) begin
                return {1'b1, 1'b1, model[i].sym, model[i].len, 4'(i)};
            end
        end
        return {1'b1, 13'd0};
    endfunction

    task automatic wr_entry(input int idx, input logic [7:0] code,
                            input logic [3:0] len, input logic [3:0] sym);
        @(negedge clk);
        en_conf = 1'b1; idx_conf = 4'(idx); h_conf = code; l_conf = len; d_conf = sym;
        @(negedge clk);
        en_conf = 1'b0;
        model[idx] = '{code: code, len: len, sym: sym, vld: 1'b1};
    endtask

    task automatic clear_table();
        @(negedge clk);
        new_conf = 1'b1;
        @(negedge clk);
        new_conf = 1'b0;
        for (int i = 0; i < 16; i++) model[i].vld = 1'b0;
    endtask

    // Single lookup; returns at the negedge where the result is visible.
    task automatic issue(input logic [7:0] win);
        @(negedge clk);
        in_valid = 1'b1; d2check = win; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        if (res !== 14'd0) begin
            $display("FAIL reset_outputs got=%h exp=%h", res, 14'd0); errors++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready got=%b exp=1", in_ready); errors++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_empty_miss();
        logic [13:0] exp;
        exp = expect_lookup(8'hA5);
        issue(8'hA5);
        if (res !== exp) begin
            $display("FAIL empty_miss got=%h exp=%h", res, exp); errors++;
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [13:0] e1, e2;
        wr_entry(0, 8'b10_111111, 4'd2, 4'h3);
        wr_entry(1, 8'b110_10101, 4'd3, 4'h7);
        e1 = expect_lookup(8'hB0);
        e2 = expect_lookup(8'hD4);
        @(negedge clk);
        in_valid = 1'b1; d2check = 8'hB0; out_ready = 1'b1;
        @(negedge clk);
        if (res !== e1 || res !== {1'b1, 1'b1, 4'h3, 4'd2, 4'd0}) begin
            $display("FAIL b2b_first got=%h exp=%h", res, e1); errors++;
        end
        checks++;
        d2check = 8'hD4;
        @(negedge clk);
        if (res !== e2 || res !== {1'b1, 1'b1, 4'h7, 4'd3, 4'd1}) begin
            $display("FAIL b2b_second got=%h exp=%h", res, e2); errors++;
        end
        checks++;
        in_valid = 1'b0;
        @(negedge clk);
        if (out_valid !== 1'b0) begin
            $display("FAIL b2b_drain got=%b exp=0", out_valid); errors++;
        end
        checks++;
    endtask

    task automatic test_overlap();
        logic [13:0] exp;
        clear_table();
        wr_entry(5, 8'b1_0101010, 4'd1, 4'h9);
        wr_entry(2, 8'b10_000000, 4'd2, 4'h4);
        exp = expect_lookup(8'h80);
        issue(8'h80);
        if (res !== exp || res !== {1'b1, 1'b1, 4'h4, 4'd2, 4'd2}) begin
            $display("FAIL overlap_low_idx got=%h exp=%h", res, exp); errors++;
        end
        checks++;
        exp = expect_lookup(8'hC0);
        issue(8'hC0);
        if (res !== exp) begin
            $display("FAIL overlap_short got=%h exp=%h", res, exp); errors++;
        end
        checks++;
    endtask

    task automatic test_conf_collision();
        logic [13:0] exp;
        wr_entry(0, 8'b10_000000, 4'd2, 4'h3);
        exp = expect_lookup(8'h80);
        @(negedge clk);
        new_conf = 1'b1; en_conf = 1'b1; idx_conf = 4'd0;
        h_conf = 8'hFF; l_conf = 4'd8; d_conf = 4'hF;
        in_valid = 1'b1; d2check = 8'h80; out_ready = 1'b1;
        @(negedge clk);
        new_conf = 1'b0; en_conf = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 16; i++) model[i].vld = 1'b0;
        if (res !== exp || res !== {1'b1, 1'b1, 4'h3, 4'd2, 4'd0}) begin
            $display("FAIL collision_old_entry got=%h exp=%h", res, exp); errors++;
        end
        checks++;
        exp = expect_lookup(8'h80);
        issue(8'h80);
        if (res !== exp) begin
            $display("FAIL collision_cleared got=%h exp=%h", res, exp); errors++;
        end
        checks++;
        exp = expect_lookup(8'hFF);
        issue(8'hFF);
        if (res !== exp) begin
            $display("FAIL collision_write_dropped got=%h exp=%h", res, exp); errors++;
        end
        checks++;
    endtask

    task automatic test_backpressure();
        logic [13:0] ea, eb;
        wr_entry(3, 8'b111_00000, 4'd3, 4'hA);
        wr_entry(4, 8'b0_0000000, 4'd1, 4'hB);
        ea = expect_lookup(8'hE5);
        eb = expect_lookup(8'h12);
        @(negedge clk);
        in_valid = 1'b1; d2check = 8'hE5; out_ready = 1'b0;
        @(negedge clk);
        if (res !== ea) begin
            $display("FAIL bp_first got=%h exp=%h", res, ea); errors++;
        end
        checks++;
        d2check = 8'h12;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (res !== ea) begin
                $display("FAIL bp_hold got=%h exp=%h cycle=%0d", res, ea, c); errors++;
            end
            checks++;
            if (in_ready !== 1'b0) begin
                $display("FAIL bp_in_ready got=%b exp=0 cycle=%0d", in_ready, c); errors++;
            end
            checks++;
        end
        out_ready = 1'b1;
        #1;
        if (in_ready !== 1'b1) begin
            $display("FAIL bp_release_ready got=%b exp=1", in_ready); errors++;
        end
        checks++;
        @(negedge clk);
        if (res !== eb) begin
            $display("FAIL bp_next got=%h exp=%h", res, eb); errors++;
        end
        checks++;
        in_valid = 1'b0;
        @(negedge clk);
        if (out_valid !== 1'b0) begin
            $display("FAIL bp_no_dup got=%b exp=0", out_valid); errors++;
        end
        checks++;
    endtask

    task automatic test_random();
        logic [13:0] exp_q [$];
        logic [13:0] exp;
        logic [7:0]  w;
        int          n, op, pick;
        for (int it = 0; it < 200; it++) begin
            op = int'($urandom_range(0, 19));
            if (op < 7) begin
                wr_entry(int'($urandom_range(0, 15)), 8'($urandom),
                         4'($urandom_range(0, 15)), 4'($urandom));
            end else if (op == 7) begin
                clear_table();
            end else begin
                n = int'($urandom_range(1, 4));
                for (int k = 0; k <= n; k++) begin
                    @(negedge clk);
                    if (k > 0) begin
                        exp = exp_q.pop_front();
                        if (res !== exp) begin
                            $display("FAIL random_lookup got=%h exp=%h it=%0d", res, exp, it);
                            errors++;
                        end
                        checks++;
                    end
                    if (k < n) begin
                        pick = int'($urandom_range(0, 15));
                        if ($urandom_range(0, 3) == 0)
                            w = 8'($urandom);
                        else
                            w = model[pick].code ^ (8'($urandom) >> model[pick].len);
                        exp_q.push_back(expect_lookup(w));
                        in_valid = 1'b1; d2check = w; out_ready = 1'b1;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [13:0] exp;
        clear_table();
        wr_entry(6, 8'b0101_0000, 4'd4, 4'hC);
        exp = expect_lookup(8'h5F);
        @(negedge clk);
        in_valid = 1'b1; d2check = 8'h5F; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        if (res !== exp || code_matched !== 1'b1) begin
            $display("FAIL arst_pre got=%h exp=%h", res, exp); errors++;
        end
        checks++;
        #2;
        rst = 1'b0;
        #1;
        if (res !== 14'd0) begin
            $display("FAIL arst_immediate got=%h exp=%h", res, 14'd0); errors++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) model[i].vld = 1'b0;
        exp = expect_lookup(8'h5F);
        issue(8'h5F);
        if (res !== exp) begin
            $display("FAIL arst_table_empty got=%h exp=%h", res, exp); errors++;
        end
        checks++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; new_conf = 1'b0; en_conf = 1'b0;
        idx_conf = '0; d_conf = '0; h_conf = '0; l_conf = '0;
        in_valid = 1'b0; d2check = '0; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        test_reset();
        test_empty_miss();
        test_back_to_back();
        test_overlap();
        test_conf_collision();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
